// File: rtl/firc_filter.sv
// firc_filter: 29-tap symmetric complex (I/Q) FIR filter.
//   Input FIFO -> 29-entry sample delay line -> 5-lane complex MAC array that
//   is time-multiplexed over 3 cycles (15 coefficients), then a rounding stage.
//   One output per accepted sample, at most one output every 5 cycles.
// Ports:
//   clk              rising-edge clock
//   Reset            asynchronous active-low reset
//   PushIn/SampI/Q   sample push, signed Q1.23 I/Q
//   StopIn           FIFO full (combinational from the registered count)
//   PushCoef/CoefAddr/CoefI/Q  coefficient write, signed Q3.24, addr 0..14
//   PushOut/FI/FQ    one-cycle output strobe, signed Q8.24 result
// Build option:
//   FIRC_SAT_EN      when defined, out-of-range results saturate instead of wrap.

// One complex multiplier lane with symmetric pre-add.
module firc_cmac (
  input  logic signed [23:0] ai_i, aq_i, bi_i, bq_i,
  input  logic               ctr_i,
  input  logic signed [26:0] ci_i, cq_i,
  output logic signed [52:0] re_o, im_o
);
  logic signed [24:0] pi, pq;
  logic signed [51:0] pi_ci, pq_cq, pi_cq, pq_ci;
  always_comb begin
    // Centre tap has no mirror partner.
    pi    = ctr_i ? 25'(ai_i) : 25'(ai_i) + 25'(bi_i);
    pq    = ctr_i ? 25'(aq_i) : 25'(aq_i) + 25'(bq_i);
    pi_ci = 52'(pi) * 52'(ci_i);
    pq_cq = 52'(pq) * 52'(cq_i);
    pi_cq = 52'(pi) * 52'(cq_i);
    pq_ci = 52'(pq) * 52'(ci_i);
    re_o  = 53'(pi_ci) - 53'(pq_cq);
    im_o  = 53'(pi_cq) + 53'(pq_ci);
  end
endmodule

module firc_filter #(
  parameter int FIFO_DEPTH = 16,
  parameter int NTAPS      = 29
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               PushIn,
  output logic               StopIn,
  input  logic signed [23:0] SampI,
  input  logic signed [23:0] SampQ,
  input  logic               PushCoef,
  input  logic [4:0]         CoefAddr,
  input  logic signed [26:0] CoefI,
  input  logic signed [26:0] CoefQ,
  output logic               PushOut,
  output logic signed [31:0] FI,
  output logic signed [31:0] FQ
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NCOEF = (NTAPS + 1) / 2;
  localparam int LANES = 5;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic signed [55:0] RND_HALF = 56'sd4194304;
`ifdef FIRC_SAT_EN
  localparam logic signed [55:0] SAT_MAX = 56'sd2147483647;
  localparam logic signed [55:0] SAT_MIN = -56'sd2147483648;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT0 = 3'd1;
  localparam logic [2:0] S_MULT1 = 3'd2;
  localparam logic [2:0] S_MULT2 = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;

  typedef struct packed { logic signed [23:0] i; logic signed [23:0] q; } samp_t;
  typedef struct packed { logic signed [26:0] i; logic signed [26:0] q; } coef_t;

  samp_t              fifo_q [FIFO_DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic [2:0]         state_q, state_d;
  samp_t              tap_q [NTAPS];
  coef_t              coef_q [NCOEF];
  logic signed [55:0] acc_re_q, acc_im_q, sum_re, sum_im;
  logic signed [31:0] fi_q, fq_q;
  logic               pushout_q;
  logic               push_ok, pull;
  logic [1:0]         mux_sel;
  logic [4:0]         ka, kb;

  logic [LANES-1:0][23:0] lane_ai, lane_aq, lane_bi, lane_bq;
  logic [LANES-1:0][26:0] lane_ci, lane_cq;
  logic [LANES-1:0]       lane_ctr;
  logic [LANES-1:0][52:0] lane_re, lane_im;

  assign StopIn  = (cnt_q == FULL_CNT);
  // A push while full is dropped even if a pull frees a slot this cycle.
  assign push_ok = PushIn && !StopIn;
  assign pull    = (state_q == S_IDLE) && (cnt_q != '0);
  assign PushOut = pushout_q;
  assign FI      = fi_q;
  assign FQ      = fq_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pull)      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && pull) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d = S_IDLE;
    mux_sel = 2'd0;
    case (state_q)
      S_IDLE:  state_d = pull ? S_MULT0 : S_IDLE;
      S_MULT0: state_d = S_MULT1;
      S_MULT1: begin state_d = S_MULT2; mux_sel = 2'd1; end
      S_MULT2: begin state_d = S_ROUND; mux_sel = 2'd2; end
      default: state_d = S_IDLE;
    endcase
  end

  // Group g feeds coefficient indices 5g..5g+4 and their mirrored taps.
  always_comb begin
    ka = '0; kb = '0;
    lane_ai = '0; lane_aq = '0; lane_bi = '0; lane_bq = '0;
    lane_ci = '0; lane_cq = '0; lane_ctr = '0;
    for (int j = 0; j < LANES; j++) begin
      ka = 5'(int'(mux_sel) * LANES + j);
      kb = 5'(NTAPS - 1) - ka;
      lane_ai[j]  = tap_q[ka].i;
      lane_aq[j]  = tap_q[ka].q;
      lane_bi[j]  = tap_q[kb].i;
      lane_bq[j]  = tap_q[kb].q;
      lane_ci[j]  = coef_q[ka[3:0]].i;
      lane_cq[j]  = coef_q[ka[3:0]].q;
      lane_ctr[j] = (ka == 5'(NCOEF - 1));
    end
  end

  firc_cmac u_mac [LANES-1:0] (
    .ai_i(lane_ai), .aq_i(lane_aq), .bi_i(lane_bi), .bq_i(lane_bq),
    .ctr_i(lane_ctr), .ci_i(lane_ci), .cq_i(lane_cq),
    .re_o(lane_re), .im_o(lane_im)
  );

  always_comb begin
    sum_re = '0; sum_im = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_re = sum_re + 56'($signed(lane_re[j]));
      sum_im = sum_im + 56'($signed(lane_im[j]));
    end
  end

  // Round half up at bit 23; wrap or clamp to 32 bits.
  function automatic logic [31:0] round_out(input logic signed [55:0] a);
`ifdef FIRC_SAT_EN
    logic signed [55:0] s;
    s = (a + RND_HALF) >>> 23;
    if (s > SAT_MAX)      round_out = 32'h7FFFFFFF;
    else if (s < SAT_MIN) round_out = 32'h80000000;
    else                  round_out = s[31:0];
`else
    round_out = 32'((a + RND_HALF) >>> 23);
`endif
  endfunction

  // Storage without reset: FIFO payload and coefficients.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q] <= '{i: SampI, q: SampQ};
    if (PushCoef && (CoefAddr < 5'(NCOEF)))
      coef_q[CoefAddr[3:0]] <= '{i: CoefI, q: CoefQ};
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      fi_q      <= '0;
      fq_q      <= '0;
      pushout_q <= 1'b0;
      for (int t = 0; t < NTAPS; t++) tap_q[t] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pushout_q <= (state_q == S_ROUND);
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pull) begin
        rptr_q   <= rptr_q + PTR_ONE;
        tap_q[0] <= fifo_q[rptr_q];
        for (int t = 1; t < NTAPS; t++) tap_q[t] <= tap_q[t-1];
      end
      case (state_q)
        S_MULT0: begin
          acc_re_q <= sum_re;
          acc_im_q <= sum_im;
        end
        S_MULT1, S_MULT2: begin
          acc_re_q <= acc_re_q + sum_re;
          acc_im_q <= acc_im_q + sum_im;
        end
        S_ROUND: begin
          fi_q <= round_out(acc_re_q);
          fq_q <= round_out(acc_im_q);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_firc_filter.sv
// Self-checking bench for firc_filter: directed spec cases plus randomized
// streams checked against a convolution model of the filter.
module tb_firc_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               Reset, PushIn, StopIn, PushCoef, PushOut;
  logic signed [23:0] SampI, SampQ;
  logic [4:0]         CoefAddr;
  logic signed [26:0] CoefI, CoefQ;
  logic [31:0]        FI, FQ;

  firc_filter dut (
    .clk(clk), .Reset(Reset), .PushIn(PushIn), .StopIn(StopIn),
    .SampI(SampI), .SampQ(SampQ), .PushCoef(PushCoef), .CoefAddr(CoefAddr),
    .CoefI(CoefI), .CoefQ(CoefQ), .PushOut(PushOut), .FI(FI), .FQ(FQ)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor (capture only).
  logic [31:0] got_i[$], got_q[$];
  int          got_c[$];
  always @(negedge clk)
    if (Reset === 1'b1 && PushOut === 1'b1) begin
      got_i.push_back(FI); got_q.push_back(FQ); got_c.push_back(cyc);
    end

  // Reference model: sample history, coefficient bank, expected outputs.
  longint      mi[29], mq[29], mci[15], mcq[15];
  logic [31:0] exp_i[$], exp_q[$];

  function automatic logic [31:0] mround(input longint a);
    longint r;
    r = (a + 64'sd4194304) >>> 23;
`ifdef FIRC_SAT_EN
    if (r > 64'sh7FFFFFFF) r = 64'sh7FFFFFFF;
    else if (r < -64'sh80000000) r = -64'sh80000000;
`endif
    return r[31:0];
  endfunction

  function automatic void model_accept(input logic signed [23:0] si, input logic signed [23:0] sq);
    longint ar, ai, pI, pQ;
    for (int t = 28; t > 0; t--) begin mi[t] = mi[t-1]; mq[t] = mq[t-1]; end
    mi[0] = longint'(si); mq[0] = longint'(sq);
    ar = 0; ai = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 14) begin pI = mi[14]; pQ = mq[14]; end
      else begin pI = mi[k] + mi[28-k]; pQ = mq[k] + mq[28-k]; end
      ar += pI * mci[k] - pQ * mcq[k];
      ai += pI * mcq[k] + pQ * mci[k];
    end
    exp_i.push_back(mround(ar)); exp_q.push_back(mround(ai));
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 29; t++) begin mi[t] = 0; mq[t] = 0; end
    exp_i.delete(); exp_q.delete();
    got_i.delete(); got_q.delete(); got_c.delete();
  endfunction

  task automatic do_reset();
    @(negedge clk); Reset = 1'b0; PushIn = 1'b0; PushCoef = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input logic [4:0] a, input logic signed [26:0] ci, input logic signed [26:0] cq);
    @(negedge clk); PushCoef = 1'b1; CoefAddr = a; CoefI = ci; CoefQ = cq;
    @(negedge clk); PushCoef = 1'b0;
    if (a < 5'd15) begin mci[a] = longint'(ci); mcq[a] = longint'(cq); end
  endtask

  task automatic load_zero();
    for (int k = 0; k < 15; k++) write_coef(5'(k), '0, '0);
  endtask

  task automatic push_only(input logic signed [23:0] si, input logic signed [23:0] sq);
    @(negedge clk); PushIn = 1'b1; SampI = si; SampQ = sq;
    @(negedge clk); PushIn = 1'b0;
    model_accept(si, sq);
  endtask

  // Push one sample into an idle filter and collect its output.
  task automatic send_one(input logic signed [23:0] si, input logic signed [23:0] sq,
                          output logic [31:0] oi, output logic [31:0] oq,
                          output int oc, output int st, output bit ok);
    @(negedge clk); PushIn = 1'b1; SampI = si; SampQ = sq; st = cyc + 1;
    @(negedge clk); PushIn = 1'b0;
    model_accept(si, sq);
    ok = 1'b0; oi = '0; oq = '0; oc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (got_i.size() > 0) begin
        oi = got_i.pop_front(); oq = got_q.pop_front(); oc = got_c.pop_front(); ok = 1'b1;
      end else @(negedge clk);
    end
  endtask

  task automatic wait_outputs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if (got_i.size() >= n) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (PushOut !== 1'b0) begin n_bad++; $display("FAIL reset_pushout got=%b want=0", PushOut); end
    n_cmp++; if (FI !== 32'h0) begin n_bad++; $display("FAIL reset_fi got=%h want=0", FI); end
    n_cmp++; if (FQ !== 32'h0) begin n_bad++; $display("FAIL reset_fq got=%h want=0", FQ); end
    n_cmp++; if (StopIn !== 1'b0) begin n_bad++; $display("FAIL reset_stopin got=%b want=0", StopIn); end
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_impulse();
    logic [31:0] oi, oq, ei; int oc, st; bit ok;
    do_reset(); load_zero(); write_coef(5'd0, 27'sh1000000, '0);
    for (int n = 0; n < 29; n++) begin
      send_one((n == 0) ? 24'sh400000 : 24'sh0, 24'sh0, oi, oq, oc, st, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL impulse_timeout n=%0d got=none want=output", n); end
      else begin
        ei = (n == 0 || n == 28) ? 32'h00800000 : 32'h0;
        n_cmp++; if (oc - st !== 5) begin n_bad++; $display("FAIL impulse_latency n=%0d got=%0d want=5", n, oc - st); end
        n_cmp++; if (oi !== ei) begin n_bad++; $display("FAIL impulse_fi n=%0d got=%h want=%h", n, oi, ei); end
        n_cmp++; if (oq !== 32'h0) begin n_bad++; $display("FAIL impulse_fq n=%0d got=%h want=0", n, oq); end
        while (cyc < oc + 1) @(negedge clk);
        n_cmp++; if (PushOut !== 1'b0) begin n_bad++; $display("FAIL impulse_strobe_width n=%0d got=%b want=0", n, PushOut); end
      end
    end
  endtask

  task automatic test_center();
    logic [31:0] oi, oq, eq; int oc, st; bit ok;
    do_reset(); load_zero(); write_coef(5'd14, '0, 27'sh1000000);
    for (int n = 0; n < 15; n++) begin
      send_one((n == 0) ? 24'sh400000 : 24'sh0, 24'sh0, oi, oq, oc, st, ok);
      eq = (n == 14) ? 32'h00800000 : 32'h0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL center_timeout n=%0d got=none want=output", n); end
      else if (oi !== 32'h0 || oq !== eq) begin
        n_bad++; $display("FAIL center_out n=%0d got=%h/%h want=00000000/%h", n, oi, oq, eq);
      end
    end
  endtask

  task automatic test_round();
    logic [31:0] oi, oq; int oc, st; bit ok;
    logic signed [23:0] s[3];
    logic [31:0] e[3];
    s[0] = 24'sh400000; s[1] = 24'sh3FFFFF; s[2] = -24'sh400000;
    e[0] = 32'h1;       e[1] = 32'h0;       e[2] = 32'h0;
    do_reset(); load_zero(); write_coef(5'd0, 27'sd1, '0);
    for (int n = 0; n < 3; n++) begin
      send_one(s[n], 24'sh0, oi, oq, oc, st, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL round_timeout n=%0d got=none want=output", n); end
      else if (oi !== e[n] || oq !== 32'h0) begin
        n_bad++; $display("FAIL round_out n=%0d got=%h/%h want=%h/00000000", n, oi, oq, e[n]);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] oi, oq; int oc, st; bit ok;
    logic [4:0] a[4];
    a[0] = 5'd15; a[1] = 5'd16; a[2] = 5'd30; a[3] = 5'd31;
    do_reset(); load_zero();
    for (int n = 0; n < 4; n++) write_coef(a[n], 27'($urandom) | 27'sd1, 27'($urandom) | 27'sd1);
    for (int n = 0; n < 5; n++) begin
      send_one(24'($urandom), 24'($urandom), oi, oq, oc, st, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL badaddr_timeout n=%0d got=none want=output", n); end
      else if (oi !== 32'h0 || oq !== 32'h0) begin
        n_bad++; $display("FAIL badaddr_out n=%0d got=%h/%h want=0/0", n, oi, oq);
      end
    end
  endtask

  task automatic test_random();
    bit ok; logic [31:0] gi, gq, ei, eq;
    do_reset();
    for (int k = 0; k < 15; k++) write_coef(5'(k), 27'($urandom), 27'($urandom));
    for (int n = 0; n < 40; n++) begin
      push_only(24'($urandom), 24'($urandom));
      repeat ($urandom_range(4, 8)) @(negedge clk);
    end
    wait_outputs(40, 200, ok);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got_i.size() !== 40) begin n_bad++; $display("FAIL random_count got=%0d want=40", got_i.size()); end
    while (got_i.size() > 0 && exp_i.size() > 0) begin
      gi = got_i.pop_front(); gq = got_q.pop_front(); ei = exp_i.pop_front(); eq = exp_q.pop_front();
      void'(got_c.pop_front());
      n_cmp++;
      if (gi !== ei || gq !== eq) begin n_bad++; $display("FAIL random_out got=%h/%h want=%h/%h", gi, gq, ei, eq); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, efull; logic [31:0] gi, gq, ei, eq;
    do_reset();
    for (int k = 0; k < 15; k++) write_coef(5'(k), 27'sh3FFFFFF, 27'sh3FFFFFF);
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      efull = (t == 20 || t == 21 || t == 23);
      n_cmp++;
      if (StopIn !== efull) begin n_bad++; $display("FAIL b2b_stopin t=%0d got=%b want=%b", t, StopIn, efull); end
      PushIn = 1'b1; SampI = 24'sh7FFFFF; SampQ = -24'sh800000;
      if (!efull) model_accept(24'sh7FFFFF, -24'sh800000);
    end
    @(negedge clk); PushIn = 1'b0;
    wait_outputs(21, 300, ok);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (got_i.size() !== 21) begin n_bad++; $display("FAIL b2b_count got=%0d want=21", got_i.size()); end
    while (got_i.size() > 0 && exp_i.size() > 0) begin
      gi = got_i.pop_front(); gq = got_q.pop_front(); ei = exp_i.pop_front(); eq = exp_q.pop_front();
      void'(got_c.pop_front());
      n_cmp++;
      if (gi !== ei || gq !== eq) begin n_bad++; $display("FAIL b2b_out got=%h/%h want=%h/%h", gi, gq, ei, eq); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] gi, gq, ei, eq;
    for (int k = 0; k < 15; k++) write_coef(5'(k), 27'($urandom), 27'($urandom));
    for (int n = 0; n < 3; n++) push_only(24'($urandom), 24'($urandom));
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    got_i.delete(); got_q.delete(); got_c.delete();
    @(negedge clk);
    n_cmp++; if (PushOut !== 1'b0) begin n_bad++; $display("FAIL midrst_pushout got=%b want=0", PushOut); end
    n_cmp++; if (FI !== 32'h0 || FQ !== 32'h0) begin n_bad++; $display("FAIL midrst_out got=%h/%h want=0/0", FI, FQ); end
    n_cmp++; if (StopIn !== 1'b0) begin n_bad++; $display("FAIL midrst_stopin got=%b want=0", StopIn); end
    @(negedge clk); Reset = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    n_cmp++;
    if (got_i.size() !== 0) begin n_bad++; $display("FAIL midrst_aborted got=%0d want=0", got_i.size()); end
    for (int n = 0; n < 6; n++) begin
      push_only(24'($urandom), 24'($urandom));
      repeat (5) @(negedge clk);
    end
    wait_outputs(6, 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_count got=%0d want=6", got_i.size()); end
    while (got_i.size() > 0 && exp_i.size() > 0) begin
      gi = got_i.pop_front(); gq = got_q.pop_front(); ei = exp_i.pop_front(); eq = exp_q.pop_front();
      void'(got_c.pop_front());
      n_cmp++;
      if (gi !== ei || gq !== eq) begin n_bad++; $display("FAIL midrst_out got=%h/%h want=%h/%h", gi, gq, ei, eq); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; PushIn = 1'b0; PushCoef = 1'b0;
    SampI = '0; SampQ = '0; CoefAddr = '0; CoefI = '0; CoefQ = '0;
    test_reset();
    test_impulse();
    test_center();
    test_round();
    test_bad_addr();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
